// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared widths, FSM encodings and requester IDs for the RAM arbiter.
// Rev 1.0
`default_nettype none

package ram_arbiter_pkg;
  localparam int RAM_ADDR_WIDTH = 10;
  localparam int RAM_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_IF = 1'b0,
    ARB_DM = 1'b1
  } arb_id_t;
endpackage

`default_nettype wire

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester handshakes plus the RAM port, seen from the arbiter (slave) and its peers (master).
// Rev 1.0
`default_nettype none

interface ram_arbiter_if;
  import ram_arbiter_pkg::*;

  logic                      if_req;
  logic [RAM_ADDR_WIDTH-1:0] if_addr;
  logic                      if_ack;
  logic [RAM_DATA_WIDTH-1:0] if_rdata;

  logic                      dm_req;
  logic                      dm_we;
  logic [RAM_ADDR_WIDTH-1:0] dm_addr;
  logic [RAM_DATA_WIDTH-1:0] dm_wdata;
  logic                      dm_ack;
  logic [RAM_DATA_WIDTH-1:0] dm_rdata;

  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic                      ram_we;
  logic [RAM_DATA_WIDTH-1:0] ram_wdata;
  logic [RAM_DATA_WIDTH-1:0] ram_rdata;

  logic                      busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, ram_addr, ram_we, ram_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, ram_addr, ram_we, ram_wdata, busy
  );
endinterface

`default_nettype wire

// File: rtl/ram_arbiter_pick.sv
// ram_arbiter_pick: combinational two-way grant with round-robin tie-break on the last granted requester.
// Rev 1.0
`default_nettype none

module ram_arbiter_pick
  import ram_arbiter_pkg::*;
(
  input  logic    if_req,
  input  logic    dm_req,
  input  logic    if_elig,
  input  logic    dm_elig,
  input  arb_id_t last,
  output logic    gnt_valid,
  output arb_id_t gnt_id
);

  logic if_ok;
  logic dm_ok;

  assign if_ok = if_req & if_elig;
  assign dm_ok = dm_req & dm_elig;

  always_comb begin
    gnt_valid = if_ok | dm_ok;
    gnt_id    = ARB_IF;
    if (if_ok && dm_ok) begin
      // On a tie the requester that was not served last goes next
      gnt_id = (last == ARB_IF) ? ARB_DM : ARB_IF;
    end else if (dm_ok) begin
      gnt_id = ARB_DM;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between fetch and data requesters, one access at a time.
// Rev 1.0
`default_nettype none

module ram_arbiter
  import ram_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);

  arb_state_t                state;
  arb_id_t                   winner;
  arb_id_t                   last_q;
  logic [RAM_ADDR_WIDTH-1:0] addr_q;
  logic [RAM_DATA_WIDTH-1:0] wdata_q;
  logic                      we_q;
  logic                      if_ack_q;
  logic                      dm_ack_q;
  logic                      busy_q;

  logic                      gnt_valid;
  arb_id_t                   gnt_id;
  logic                      if_elig;
  logic                      dm_elig;

  // The requester just acked still holds req during RESP and must not be re-granted there
  assign if_elig = !((state == ARB_RESP) && (winner == ARB_IF));
  assign dm_elig = !((state == ARB_RESP) && (winner == ARB_DM));

  ram_arbiter_pick u_pick (
    .if_req    (bus.if_req),
    .dm_req    (bus.dm_req),
    .if_elig   (if_elig),
    .dm_elig   (dm_elig),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      winner   <= ARB_IF;
      last_q   <= ARB_IF;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state)
        ARB_IDLE, ARB_RESP: begin
          if (gnt_valid) begin
            winner <= gnt_id;
            last_q <= gnt_id;
            if (gnt_id == ARB_DM) begin
              addr_q  <= bus.dm_addr;
              we_q    <= bus.dm_we;
              wdata_q <= bus.dm_wdata;
            end else begin
              addr_q  <= bus.if_addr;
              we_q    <= 1'b0;
            end
            state  <= ARB_ACCESS;
            busy_q <= 1'b1;
          end else begin
            state  <= ARB_IDLE;
            busy_q <= 1'b0;
          end
        end
        ARB_ACCESS: begin
          if_ack_q <= (winner == ARB_IF);
          dm_ack_q <= (winner == ARB_DM);
          state    <= ARB_RESP;
          busy_q   <= 1'b1;
        end
        default: begin
          state  <= ARB_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // addr_q holds after ACCESS so the RAM's registered read stays valid through RESP
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.ram_we    = (state == ARB_ACCESS) & we_q & ~rst;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.if_rdata  = bus.ram_rdata;
  assign bus.dm_rdata  = bus.ram_rdata;
  assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter against a behavioural single-port RAM.
// Rev 1.0
`default_nettype none

module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic                      preload_en   = 1'b0;
  logic [RAM_ADDR_WIDTH-1:0] preload_addr = '0;
  logic [RAM_DATA_WIDTH-1:0] preload_data = '0;
  logic [RAM_DATA_WIDTH-1:0] mem [0:(1<<RAM_ADDR_WIDTH)-1];

  int n_cmp = 0;
  int n_err = 0;

  ram_arbiter_if bus ();

  ram_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one-cycle registered read
  always @(posedge clk) begin
    if (preload_en)
      mem[preload_addr] <= preload_data;
    else if (bus.ram_we)
      mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n_if_acks;
    int n_dm_acks;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;

    preload_en = 1'b1; preload_addr = 10'h010; preload_data = 32'hDEADBEEF;
    cyc();
    preload_addr = 10'h030; preload_data = 32'h11111111;
    cyc();
    preload_en = 1'b0;
    cyc();
    rst = 1'b0;

    check("reset_busy",     32'(bus.busy),     32'd0);
    check("reset_if_ack",   32'(bus.if_ack),   32'd0);
    check("reset_dm_ack",   32'(bus.dm_ack),   32'd0);
    check("reset_ram_we",   32'(bus.ram_we),   32'd0);
    check("reset_ram_addr", 32'(bus.ram_addr), 32'd0);

    // Fetch only
    bus.if_req = 1'b1; bus.if_addr = 10'h010;
    cyc();
    check("fetch_c1_busy",  32'(bus.busy),     32'd1);
    check("fetch_c1_addr",  32'(bus.ram_addr), 32'h010);
    check("fetch_c1_ack",   32'(bus.if_ack),   32'd0);
    cyc();
    check("fetch_c2_ack",   32'(bus.if_ack),   32'd1);
    check("fetch_c2_rdata", bus.if_rdata,      32'hDEADBEEF);
    check("fetch_c2_dmack", 32'(bus.dm_ack),   32'd0);
    cyc();
    bus.if_req = 1'b0;
    check("fetch_c3_busy",  32'(bus.busy),     32'd0);
    check("fetch_c3_ack",   32'(bus.if_ack),   32'd0);

    // Store then load
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 10'h020; bus.dm_wdata = 32'h12345678;
    cyc();
    check("store_c1_we",    32'(bus.ram_we),   32'd1);
    check("store_c1_wdata", bus.ram_wdata,     32'h12345678);
    check("store_c1_ack",   32'(bus.dm_ack),   32'd0);
    cyc();
    check("store_c2_ack",   32'(bus.dm_ack),   32'd1);
    check("store_c2_we",    32'(bus.ram_we),   32'd0);
    check("store_c2_ifack", 32'(bus.if_ack),   32'd0);
    cyc();
    bus.dm_we = 1'b0;
    check("store_c3_ack",   32'(bus.dm_ack),   32'd0);
    cyc();
    check("load_c1_we",     32'(bus.ram_we),   32'd0);
    check("load_c1_ack",    32'(bus.dm_ack),   32'd0);
    cyc();
    check("load_c2_ack",    32'(bus.dm_ack),   32'd1);
    check("load_c2_rdata",  bus.dm_rdata,      32'h12345678);
    cyc();
    bus.dm_req = 1'b0;

    // Conflict right after reset: data first, then fetch back-to-back
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 10'h010;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'h020;
    cyc();
    check("conf_c1_busy",   32'(bus.busy),     32'd1);
    check("conf_c1_addr",   32'(bus.ram_addr), 32'h020);
    cyc();
    check("conf_c2_dmack",  32'(bus.dm_ack),   32'd1);
    check("conf_c2_ifack",  32'(bus.if_ack),   32'd0);
    check("conf_c2_rdata",  bus.dm_rdata,      32'h12345678);
    check("conf_c2_busy",   32'(bus.busy),     32'd1);
    cyc();
    bus.dm_req = 1'b0;
    check("conf_c3_busy",   32'(bus.busy),     32'd1);
    check("conf_c3_addr",   32'(bus.ram_addr), 32'h010);
    check("conf_c3_acks",   32'({bus.if_ack, bus.dm_ack}), 32'd0);
    cyc();
    check("conf_c4_ifack",  32'(bus.if_ack),   32'd1);
    check("conf_c4_dmack",  32'(bus.dm_ack),   32'd0);
    check("conf_c4_rdata",  bus.if_rdata,      32'hDEADBEEF);
    check("conf_c4_busy",   32'(bus.busy),     32'd1);
    cyc();
    bus.if_req = 1'b0;
    check("conf_c5_busy",   32'(bus.busy),     32'd0);
    cyc();

    // Continuous contention: fetch was served last, so data leads and grants alternate
    bus.if_req = 1'b1; bus.dm_req = 1'b1;
    n_if_acks = 0; n_dm_acks = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      check("cont_odd_acks", 32'({bus.if_ack, bus.dm_ack}), 32'd0);
      check("cont_odd_busy", 32'(bus.busy), 32'd1);
      cyc();
      if (k % 2 == 0) begin
        check("cont_dm_ack", 32'({bus.if_ack, bus.dm_ack}), 32'b01);
        check("cont_dm_rdata", bus.dm_rdata, 32'h12345678);
      end else begin
        check("cont_if_ack", 32'({bus.if_ack, bus.dm_ack}), 32'b10);
        check("cont_if_rdata", bus.if_rdata, 32'hDEADBEEF);
      end
      if (bus.if_ack) n_if_acks++;
      if (bus.dm_ack) n_dm_acks++;
    end
    check("cont_if_count", 32'(n_if_acks), 32'd4);
    check("cont_dm_count", 32'(n_dm_acks), 32'd4);
    cyc();
    bus.if_req = 1'b0;
    check("cont_tail_busy", 32'(bus.busy), 32'd1);
    cyc();
    check("cont_tail_dmack", 32'(bus.dm_ack), 32'd1);
    check("cont_tail_ifack", 32'(bus.if_ack), 32'd0);
    cyc();

    // Reset during ACCESS of a write: write suppressed, no ack
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 10'h030; bus.dm_wdata = 32'hA5A5A5A5;
    cyc();
    check("rst_c1_we_pre", 32'(bus.ram_we), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_c1_we_gated", 32'(bus.ram_we), 32'd0);
    cyc();
    rst = 1'b0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    check("rst_c2_busy",   32'(bus.busy),   32'd0);
    check("rst_c2_dmack",  32'(bus.dm_ack), 32'd0);
    cyc();
    check("rst_c3_dmack",  32'(bus.dm_ack), 32'd0);
    check("rst_c3_busy",   32'(bus.busy),   32'd0);
    bus.dm_req = 1'b1; bus.dm_addr = 10'h030;
    cyc();
    cyc();
    check("rst_readback_ack",   32'(bus.dm_ack), 32'd1);
    check("rst_readback_rdata", bus.dm_rdata,    32'h11111111);
    cyc();
    bus.dm_req = 1'b0;

    // Acked requester keeps requesting with the other idle: RESP -> IDLE -> ACCESS
    bus.if_req = 1'b1; bus.if_addr = 10'h010;
    cyc();
    cyc();
    check("rereq_first_ack", 32'(bus.if_ack), 32'd1);
    cyc();
    check("rereq_idle_busy", 32'(bus.busy),   32'd0);
    check("rereq_idle_ack",  32'(bus.if_ack), 32'd0);
    cyc();
    check("rereq_acc_busy",  32'(bus.busy),   32'd1);
    check("rereq_acc_ack",   32'(bus.if_ack), 32'd0);
    cyc();
    check("rereq_second_ack",   32'(bus.if_ack), 32'd1);
    check("rereq_second_rdata", bus.if_rdata,    32'hDEADBEEF);
    cyc();
    bus.if_req = 1'b0;
    cyc();
    check("final_busy", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
